// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, word
// relation encoding and the relation-to-flag mapping.
package serial_cmp_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_GT = 2'b01,
    REL_LT = 2'b10
  } rel_t;

  // Returns {gt, eq, lt}; always one-hot for a legal relation.
  function automatic logic [2:0] rel_to_flags(input rel_t rel);
    logic [2:0] flags;
    case (rel)
      REL_GT:  flags = 3'b100;
      REL_EQ:  flags = 3'b010;
      REL_LT:  flags = 3'b001;
      default: flags = '0;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Bit-pair input stream, result handshake and flush for the serial comparator.
interface serial_magnitude_comparator_if;

  logic flush;
  logic in_valid;
  logic in_ready;
  logic a_bit;
  logic b_bit;
  logic res_valid;
  logic res_ready;
  logic gt;
  logic eq;
  logic lt;

  modport master (
    output flush, in_valid, a_bit, b_bit, res_ready,
    input  in_ready, res_valid, gt, eq, lt
  );

  modport slave (
    input  flush, in_valid, a_bit, b_bit, res_ready,
    output in_ready, res_valid, gt, eq, lt
  );

endinterface

// File: rtl/serial_magnitude_comparator_bit_relation_cell.sv
// Single-bit comparator: exactly one of gt/eq/lt is high for a_bit vs b_bit.
module bit_relation_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a_bit & ~b_bit;
  assign lt = ~a_bit & b_bit;
  assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Accumulates WIDTH per-bit relations into one word verdict and holds it
// until the consumer takes it.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                           clk,
  input logic                           rst,
  serial_magnitude_comparator_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  rel_t          acc_q, acc_d;
  rel_t          bit_rel, rel_upd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    flags_q, flags_d;
  logic          bit_gt, bit_eq, bit_lt;
  logic          ready;
  logic          beat;

  bit_relation_cell u_cell (
    .a_bit (bus.a_bit),
    .b_bit (bus.b_bit),
    .gt    (bit_gt),
    .eq    (bit_eq),
    .lt    (bit_lt)
  );

  // Gated by rst so the input side looks closed for the whole reset pulse.
  assign ready = (state_q == COLLECT) && !rst;
  assign beat  = bus.in_valid && ready;

  assign bus.in_ready  = ready;
  assign bus.res_valid = (state_q == HOLD);
  assign bus.gt        = flags_q[2];
  assign bus.eq        = flags_q[1];
  assign bus.lt        = flags_q[0];

  always_comb begin
    bit_rel = bit_gt ? REL_GT : (bit_lt ? REL_LT : REL_EQ);
    rel_upd = acc_q;
    if (MSB_FIRST) begin
      if (acc_q == REL_EQ) rel_upd = bit_rel;
    end else begin
      if (!bit_eq) rel_upd = bit_rel;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    if (bus.flush) begin
      state_d = COLLECT;
      cnt_d   = '0;
      acc_d   = REL_EQ;
      flags_d = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (beat) begin
            if (cnt_q == LAST) begin
              state_d = HOLD;
              cnt_d   = '0;
              acc_d   = REL_EQ;
              flags_d = rel_to_flags(rel_upd);
            end else begin
              cnt_d = cnt_q + 1'b1;
              acc_d = rel_upd;
            end
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            state_d = COLLECT;
            flags_d = '0;
          end
        end
        default: begin
          state_d = COLLECT;
          cnt_d   = '0;
          acc_d   = REL_EQ;
          flags_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      acc_q   <= REL_EQ;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench: one MSB-first and one LSB-first comparator fed the same stream.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic res_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator_if bus_m ();
  serial_magnitude_comparator_if bus_l ();

  assign bus_m.flush     = flush;
  assign bus_m.in_valid  = in_valid;
  assign bus_m.a_bit     = a_bit;
  assign bus_m.b_bit     = b_bit;
  assign bus_m.res_ready = res_ready;
  assign bus_l.flush     = flush;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.a_bit     = a_bit;
  assign bus_l.b_bit     = b_bit;
  assign bus_l.res_ready = res_ready;

  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives n beats of words a/b; optional idle cycle between beats.
  task automatic send_bits(input logic [7:0] a, input logic [7:0] b,
                           input bit lsb_first, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = lsb_first ? i : 7 - i;
      in_valid = 1'b1;
      a_bit = a[idx];
      b_bit = b[idx];
      cycle();
      if (gap && i < n - 1) begin
        in_valid = 1'b0;
        cycle();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_m(input string tag, input logic g, input logic e, input logic l);
    chk({tag, "_m_valid"}, bus_m.res_valid, 1'b1);
    chk({tag, "_m_gt"}, bus_m.gt, g);
    chk({tag, "_m_eq"}, bus_m.eq, e);
    chk({tag, "_m_lt"}, bus_m.lt, l);
  endtask

  task automatic chk_l(input string tag, input logic g, input logic e, input logic l);
    chk({tag, "_l_valid"}, bus_l.res_valid, 1'b1);
    chk({tag, "_l_gt"}, bus_l.gt, g);
    chk({tag, "_l_eq"}, bus_l.eq, e);
    chk({tag, "_l_lt"}, bus_l.lt, l);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", bus_m.in_ready, 1'b0);
    chk("rst_res_valid", bus_m.res_valid, 1'b0);
    chk("rst_gt", bus_m.gt, 1'b0);
    chk("rst_eq", bus_m.eq, 1'b0);
    chk("rst_lt", bus_m.lt, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", bus_m.in_ready, 1'b1);
    chk("rel_res_valid", bus_m.res_valid, 1'b0);

    // 1: equal words, result one cycle after the 8th accept
    res_ready = 1'b1;
    send_bits(8'hA5, 8'hA5, 1'b0, 8, 1'b0);
    chk_m("t1", 1'b0, 1'b1, 1'b0);
    chk_l("t1", 1'b0, 1'b1, 1'b0);
    chk("t1_in_ready_hold", bus_m.in_ready, 1'b0);
    cycle();
    chk("t1_valid_clr", bus_m.res_valid, 1'b0);
    chk("t1_in_ready_back", bus_m.in_ready, 1'b1);
    chk("t1_eq_clr", bus_m.eq, 1'b0);

    // 2: decided at first bit, then only at last bit
    send_bits(8'h80, 8'h7F, 1'b0, 8, 1'b0);
    chk_m("t2a", 1'b1, 1'b0, 1'b0);
    chk_l("t2a", 1'b0, 1'b0, 1'b1);
    cycle();
    send_bits(8'h12, 8'h13, 1'b0, 8, 1'b0);
    chk_m("t2b", 1'b0, 1'b0, 1'b1);
    chk_l("t2b", 1'b0, 1'b0, 1'b1);
    cycle();

    // 3: LSB-first stream, last differing bit wins for the LSB-first block
    send_bits(8'h01, 8'h80, 1'b1, 8, 1'b0);
    chk_l("t3", 1'b0, 1'b0, 1'b1);
    chk_m("t3", 1'b1, 1'b0, 1'b0);
    cycle();

    // 4: result backpressure with in_valid held high
    res_ready = 1'b0;
    send_bits(8'hFF, 8'h00, 1'b0, 8, 1'b0);
    in_valid = 1'b1;
    a_bit = 1'b0;
    b_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", bus_m.res_valid, 1'b1);
      chk("t4_gt", bus_m.gt, 1'b1);
      chk("t4_lt", bus_m.lt, 1'b0);
      chk("t4_in_ready", bus_m.in_ready, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    cycle();
    chk("t4_valid_clr", bus_m.res_valid, 1'b0);
    chk("t4_in_ready", bus_m.in_ready, 1'b1);
    chk("t4_gt_clr", bus_m.gt, 1'b0);

    // 5a: flush mid-word discards the partial LT
    send_bits(8'h00, 8'hFF, 1'b0, 3, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t5_flush_valid", bus_m.res_valid, 1'b0);
    chk("t5_flush_ready", bus_m.in_ready, 1'b1);
    send_bits(8'hFF, 8'h00, 1'b0, 8, 1'b0);
    chk_m("t5a", 1'b1, 1'b0, 1'b0);
    chk_l("t5a", 1'b1, 1'b0, 1'b0);
    cycle();

    // 5b: flush discards a held result
    res_ready = 1'b0;
    send_bits(8'h12, 8'h13, 1'b0, 8, 1'b0);
    chk_m("t5b", 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t5b_valid_clr", bus_m.res_valid, 1'b0);
    chk("t5b_lt_clr", bus_m.lt, 1'b0);
    chk("t5b_in_ready", bus_m.in_ready, 1'b1);

    // 5c: asynchronous reset mid-word, then in HOLD
    send_bits(8'h00, 8'hFF, 1'b0, 3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("t5c_mid_in_ready", bus_m.in_ready, 1'b0);
    chk("t5c_mid_valid", bus_m.res_valid, 1'b0);
    #2;
    rst = 1'b0;
    cycle();
    chk("t5c_ready_after", bus_m.in_ready, 1'b1);
    send_bits(8'hA5, 8'h5A, 1'b0, 8, 1'b0);
    chk_m("t5c", 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("t5c_hold_valid", bus_m.res_valid, 1'b0);
    chk("t5c_hold_gt", bus_m.gt, 1'b0);
    chk("t5c_hold_eq", bus_m.eq, 1'b0);
    chk("t5c_hold_lt", bus_m.lt, 1'b0);
    chk("t5c_hold_in_ready", bus_m.in_ready, 1'b0);
    #2;
    rst = 1'b0;
    cycle();
    res_ready = 1'b1;

    // 6: gapped stream gives the contiguous result
    send_bits(8'h3C, 8'h3C, 1'b0, 8, 1'b1);
    chk_m("t6", 1'b0, 1'b1, 1'b0);
    chk_l("t6", 1'b0, 1'b1, 1'b0);
    cycle();
    chk("t6_valid_clr", bus_m.res_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
